rggen_native_split_adapter: RTL and testbench

Front end that turns a split-transaction native CSR bus into the single-outstanding request/ready bus consumed by rggen_adapter_common. Command and response are separate valid/ready channels, each tagged with an ID. Responses are buffered in a RSP_DEPTH-entry FIFO, so a stalled response consumer does not hold the register block. An optional watchdog ends inner accesses that never complete and returns an error response.

---
 rtl/rggen_rtl_pkg.sv | 15 +
 rtl/rggen_native_split_adapter.sv | 153 +++++++++++++++
 tb/tb_rggen_native_split_adapter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings used by the rggen bus adapters.
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_READ         = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

// File: rtl/rggen_native_split_adapter.sv
// Split cmd/rsp native CSR bus to single-outstanding inner request bus,
// with a buffered response FIFO and an optional busy watchdog.
module rggen_native_split_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter int ID_WIDTH       = 4,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  rggen_access              i_cmd_access,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_cmd_strobe,
  input  logic [ID_WIDTH-1:0]      i_cmd_id,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output rggen_status              o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [ID_WIDTH-1:0]      o_rsp_id,
  output logic                     o_bus_valid,
  output rggen_access              o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [STROBE_WIDTH-1:0]  o_bus_strobe,
  input  logic                     i_bus_ready,
  input  rggen_status              i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                   state;
  logic [CW-1:0]            count;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  rggen_access              cmd_access;
  logic [ADDRESS_WIDTH-1:0] cmd_address;
  logic [BUS_WIDTH-1:0]     cmd_write_data;
  logic [STROBE_WIDTH-1:0]  cmd_strobe;
  logic [ID_WIDTH-1:0]      cmd_id;

  rggen_status              fifo_status [RSP_DEPTH];
  logic [BUS_WIDTH-1:0]     fifo_data   [RSP_DEPTH];
  logic [ID_WIDTH-1:0]      fifo_id     [RSP_DEPTH];

  logic                     accept;
  logic                     done;
  logic                     timeout;
  logic                     push;
  logic                     pop;
  rggen_status              push_status;
  logic [BUS_WIDTH-1:0]     push_data;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_cmd_ready = (state == IDLE)
                    && (count < CW'(RSP_DEPTH));
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign done        = (state == BUSY) && i_bus_ready;
  assign push        = done || timeout;
  assign pop         = o_rsp_valid && i_rsp_ready;

  // a completion coinciding with the watchdog wins
  assign push_status = done ? i_bus_status : RGGEN_SLAVE_ERROR;
  assign push_data   = (done && cmd_access == RGGEN_READ)
                     ? i_bus_read_data : '0;

  assign o_bus_valid      = (state == BUSY);
  assign o_bus_access     = cmd_access;
  assign o_bus_address    = cmd_address;
  assign o_bus_write_data = cmd_write_data;
  assign o_bus_strobe     = cmd_strobe;

  assign o_rsp_valid     = (count != '0);
  assign o_rsp_status    = fifo_status[rd_ptr];
  assign o_rsp_read_data = fifo_data[rd_ptr];
  assign o_rsp_id        = fifo_id[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (accept) state <= BUSY;
    end else begin
      if (push) state <= IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      cmd_access     <= i_cmd_access;
      cmd_address    <= i_cmd_address;
      cmd_write_data <= i_cmd_write_data;
      cmd_strobe     <= i_cmd_strobe;
      cmd_id         <= i_cmd_id;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_status[wr_ptr] <= push_status;
      fifo_data[wr_ptr]   <= push_data;
      fifo_id[wr_ptr]     <= cmd_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_wdt
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wdt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wdt <= '0;
      end else if (accept) begin
        wdt <= '0;
      end else if (state == BUSY && !i_bus_ready) begin
        wdt <= wdt + 1'b1;
      end
    end

    assign timeout = (state == BUSY) && !i_bus_ready
                  && (wdt == TW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdt
    assign timeout = 1'b0;
  end
endmodule

// File: tb/tb_rggen_native_split_adapter.sv
// Directed bench: vector table for single transactions plus
// sequences for watchdog, back-pressure, push/pop and reset.
module tb_rggen_native_split_adapter;
  import rggen_rtl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid;
  logic        cmd_ready;
  rggen_access cmd_access;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strobe;
  logic [3:0]  cmd_id;
  logic        rsp_valid;
  logic        rsp_ready;
  rggen_status rsp_status;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        bus_valid;
  rggen_access bus_access;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_ready;
  rggen_status bus_status;
  logic [31:0] bus_rdata;

  logic        c1_valid;
  logic        c1_ready;
  logic        r1_valid;
  logic        r1_ready;
  rggen_status r1_status;
  logic [31:0] r1_data;
  logic [3:0]  r1_id;
  logic        b1_valid;
  rggen_access b1_access;
  logic [7:0]  b1_addr;
  logic [31:0] b1_wdata;
  logic [3:0]  b1_strobe;
  logic        b1_ready;

  rggen_native_split_adapter #(
    .RSP_DEPTH      (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_access     (cmd_access),
    .i_cmd_address    (cmd_addr),
    .i_cmd_write_data (cmd_wdata),
    .i_cmd_strobe     (cmd_strobe),
    .i_cmd_id         (cmd_id),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_status     (rsp_status),
    .o_rsp_read_data  (rsp_data),
    .o_rsp_id         (rsp_id),
    .o_bus_valid      (bus_valid),
    .o_bus_access     (bus_access),
    .o_bus_address    (bus_addr),
    .o_bus_write_data (bus_wdata),
    .o_bus_strobe     (bus_strobe),
    .i_bus_ready      (bus_ready),
    .i_bus_status     (bus_status),
    .i_bus_read_data  (bus_rdata)
  );

  rggen_native_split_adapter #(
    .RSP_DEPTH      (1),
    .TIMEOUT_CYCLES (0)
  ) dut1 (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cmd_valid      (c1_valid),
    .o_cmd_ready      (c1_ready),
    .i_cmd_access     (cmd_access),
    .i_cmd_address    (cmd_addr),
    .i_cmd_write_data (cmd_wdata),
    .i_cmd_strobe     (cmd_strobe),
    .i_cmd_id         (cmd_id),
    .o_rsp_valid      (r1_valid),
    .i_rsp_ready      (r1_ready),
    .o_rsp_status     (r1_status),
    .o_rsp_read_data  (r1_data),
    .o_rsp_id         (r1_id),
    .o_bus_valid      (b1_valid),
    .o_bus_access     (b1_access),
    .o_bus_address    (b1_addr),
    .o_bus_write_data (b1_wdata),
    .o_bus_strobe     (b1_strobe),
    .i_bus_ready      (b1_ready),
    .i_bus_status     (bus_status),
    .i_bus_read_data  (bus_rdata)
  );

  int errors = 0;
  int checks = 0;
  int ovf    = 0;

  // a push into a full FIFO without a pop would lose a response
  always @(posedge clk) begin
    if (rst_n && dut.push && !dut.pop && dut.count == 2'd2)
      ovf <= ovf + 1;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] id, input rggen_access acc);
    int n;
    cmd_id     = id;
    cmd_access = acc;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_accept", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    rggen_access acc;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  id;
    rggen_status bst;
    logic [31:0] brd;
    rggen_status est;
    logic [31:0] erd;
  } vec_t;

  vec_t        vecs [5];
  vec_t        v;
  logic [3:0]  got [$];
  logic        acc;
  int          cnt;

  initial begin
    vecs[0] = '{RGGEN_READ, 8'h10, 32'h0, 4'h0, 4'd3,
                RGGEN_OKAY, 32'hDEADBEEF, RGGEN_OKAY, 32'hDEADBEEF};
    vecs[1] = '{RGGEN_WRITE, 8'h14, 32'h12345678, 4'hF, 4'd5,
                RGGEN_OKAY, 32'hCAFEF00D, RGGEN_OKAY, 32'h0};
    vecs[2] = '{RGGEN_POSTED_WRITE, 8'h20, 32'hA5A5A5A5, 4'h3, 4'd9,
                RGGEN_SLAVE_ERROR, 32'h11111111, RGGEN_SLAVE_ERROR, 32'h0};
    vecs[3] = '{RGGEN_READ, 8'hFC, 32'h0, 4'hF, 4'hF,
                RGGEN_DECODE_ERROR, 32'h0BADF00D,
                RGGEN_DECODE_ERROR, 32'h0BADF00D};
    vecs[4] = '{RGGEN_READ, 8'h00, 32'h0, 4'h0, 4'd0,
                RGGEN_EXOKAY, 32'h80000001, RGGEN_EXOKAY, 32'h80000001};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    c1_valid   = 1'b0;
    cmd_access = RGGEN_READ;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strobe = '0;
    cmd_id     = '0;
    rsp_ready  = 1'b1;
    r1_ready   = 1'b0;
    bus_ready  = 1'b0;
    b1_ready   = 1'b0;
    bus_status = RGGEN_OKAY;
    bus_rdata  = '0;
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_c1_ready", 32'(c1_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single transactions
    for (int i = 0; i < 5; i++) begin
      v          = vecs[i];
      cmd_access = v.acc;
      cmd_addr   = v.addr;
      cmd_wdata  = v.wdata;
      cmd_strobe = v.strb;
      cmd_id     = v.id;
      cmd_valid  = 1'b1;
      chk("v_cmd_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid  = 1'b0;
      cmd_addr   = ~v.addr;
      cmd_wdata  = ~v.wdata;
      cmd_strobe = ~v.strb;
      cmd_id     = ~v.id;
      chk("v_bus_valid", 32'(bus_valid), 32'd1);
      chk("v_bus_access", 32'(bus_access), 32'(v.acc));
      chk("v_bus_addr", 32'(bus_addr), 32'(v.addr));
      chk("v_bus_wdata", bus_wdata, v.wdata);
      chk("v_bus_strobe", 32'(bus_strobe), 32'(v.strb));
      chk("v_busy_ready", 32'(cmd_ready), 32'd0);
      chk("v_early_rsp", 32'(rsp_valid), 32'd0);
      bus_ready  = 1'b1;
      bus_status = v.bst;
      bus_rdata  = v.brd;
      step();
      bus_ready = 1'b0;
      chk("v_bus_drop", 32'(bus_valid), 32'd0);
      chk("v_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("v_rsp_status", 32'(rsp_status), 32'(v.est));
      chk("v_rsp_data", rsp_data, v.erd);
      chk("v_rsp_id", 32'(rsp_id), 32'(v.id));
      step();
      chk("v_rsp_popped", 32'(rsp_valid), 32'd0);
    end

    // watchdog expiry
    bus_status = RGGEN_OKAY;
    bus_rdata  = 32'h55;
    cmd_addr   = 8'h40;
    send(4'd7, RGGEN_READ);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_valid && bus_addr == 8'h40) cnt++;
      step();
    end
    chk("to_busy_cycles", 32'(cnt), 32'd4);
    chk("to_bus_drop", 32'(bus_valid), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_status", 32'(rsp_status), 32'(RGGEN_SLAVE_ERROR));
    chk("to_rsp_data", rsp_data, 32'h0);
    chk("to_rsp_id", 32'(rsp_id), 32'd7);
    step();

    // completion in the timeout cycle
    send(4'd8, RGGEN_READ);
    for (int k = 0; k < 3; k++) step();
    chk("to2_still_busy", 32'(bus_valid), 32'd1);
    bus_ready = 1'b1;
    bus_rdata = 32'h77770004;
    step();
    bus_ready = 1'b0;
    chk("to2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to2_rsp_status", 32'(rsp_status), 32'(RGGEN_OKAY));
    chk("to2_rsp_data", rsp_data, 32'h77770004);
    chk("to2_rsp_id", 32'(rsp_id), 32'd8);
    step();

    // pop previous response while a new completion pushes
    rsp_ready = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h1111;
    send(4'hA, RGGEN_READ);
    step();
    bus_rdata = 32'h2222;
    send(4'hB, RGGEN_READ);
    chk("pp_head_a_id", 32'(rsp_id), 32'hA);
    chk("pp_head_a_data", rsp_data, 32'h1111);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("pp_count", 32'(dut.count), 32'd1);
    chk("pp_head_b_valid", 32'(rsp_valid), 32'd1);
    chk("pp_head_b_id", 32'(rsp_id), 32'hB);
    chk("pp_head_b_data", rsp_data, 32'h2222);
    rsp_ready = 1'b1;
    step();
    chk("pp_drained", 32'(rsp_valid), 32'd0);

    // back-pressure with a full FIFO
    rsp_ready = 1'b0;
    send(4'd1, RGGEN_READ);
    step();
    send(4'd2, RGGEN_READ);
    step();
    cmd_id    = 4'd3;
    cmd_valid = 1'b1;
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    chk("bp_head_id", 32'(rsp_id), 32'd1);
    step();
    step();
    chk("bp_still_blocked", 32'(cmd_ready), 32'd0);
    chk("bp_no_bus", 32'(bus_valid), 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid && rsp_ready) got.push_back(rsp_id);
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) cmd_valid = 1'b0;
    end
    chk("bp_rsp_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("bp_order0", 32'(got[0]), 32'd1);
      chk("bp_order1", 32'(got[1]), 32'd2);
      chk("bp_order2", 32'(got[2]), 32'd3);
    end
    cmd_valid = 1'b0;
    bus_ready = 1'b0;

    // depth-1 instance without watchdog
    bus_status = RGGEN_OKAY;
    cmd_id     = 4'd6;
    cmd_access = RGGEN_READ;
    c1_valid   = 1'b1;
    chk("d1_ready", 32'(c1_ready), 32'd1);
    step();
    c1_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (b1_valid) cnt++;
      step();
    end
    chk("d1_no_timeout", 32'(cnt), 32'd8);
    b1_ready  = 1'b1;
    bus_rdata = 32'h600D;
    step();
    b1_ready = 1'b0;
    chk("d1_rsp_valid", 32'(r1_valid), 32'd1);
    chk("d1_rsp_id", 32'(r1_id), 32'd6);
    chk("d1_rsp_data", r1_data, 32'h600D);
    chk("d1_rsp_status", 32'(r1_status), 32'(RGGEN_OKAY));
    chk("d1_full", 32'(c1_ready), 32'd0);
    step();
    chk("d1_held", 32'(r1_valid), 32'd1);
    r1_ready = 1'b1;
    step();
    r1_ready = 1'b0;
    chk("d1_popped", 32'(r1_valid), 32'd0);
    chk("d1_ready_again", 32'(c1_ready), 32'd1);

    // reset while busy with a buffered response
    rsp_ready = 1'b0;
    bus_ready = 1'b1;
    send(4'd1, RGGEN_READ);
    step();
    bus_ready = 1'b0;
    send(4'd2, RGGEN_READ);
    chk("mr_pre_busy", 32'(bus_valid), 32'd1);
    chk("mr_pre_rsp", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_bus_valid", 32'(bus_valid), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rsp_ready = 1'b1;
    bus_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid || bus_valid || !cmd_ready) cnt++;
      step();
    end
    chk("mr_no_stale", 32'(cnt), 32'd0);
    chk("fifo_overflow", 32'(ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
